// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_pkg
// Brief    : Shared state encoding and output-decode constants for the gate FSM.
// Revision : 1.0 - initial release
// ============================================================================
package gate_pkg;

    localparam int C_STATE_W = 4;

    // One-hot state encoding
    localparam logic [C_STATE_W-1:0] C_ST_CERRADA    = 4'b0001;
    localparam logic [C_STATE_W-1:0] C_ST_ABIERTA    = 4'b0010;
    localparam logic [C_STATE_W-1:0] C_ST_BLOQUEADA  = 4'b0100;
    localparam logic [C_STATE_W-1:0] C_ST_SUSPENDIDA = 4'b1000;

    typedef enum logic [C_STATE_W-1:0] {
        CERRADA    = C_ST_CERRADA,
        ABIERTA    = C_ST_ABIERTA,
        BLOQUEADA  = C_ST_BLOQUEADA,
        SUSPENDIDA = C_ST_SUSPENDIDA
    } gate_state_t;

    // Decoded outputs, packed as {cerrado, abierto, alarma, bloqueo}
    localparam logic [3:0] C_OUT_CERRADA    = 4'b1000;
    localparam logic [3:0] C_OUT_ABIERTA    = 4'b0100;
    localparam logic [3:0] C_OUT_BLOQUEADA  = 4'b0011;
    localparam logic [3:0] C_OUT_SUSPENDIDA = 4'b1010;

    function automatic logic [3:0] decode_outputs(input gate_state_t st);
        logic [3:0] v;
        v = C_OUT_CERRADA;
        case (st)
            CERRADA:    v = C_OUT_CERRADA;
            ABIERTA:    v = C_OUT_ABIERTA;
            BLOQUEADA:  v = C_OUT_BLOQUEADA;
            SUSPENDIDA: v = C_OUT_SUSPENDIDA;
            default:    v = C_OUT_CERRADA;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/occupancy_counter.sv
`default_nettype none
// ============================================================================
// Module   : occupancy_counter
// Brief    : Saturating up/down vehicle counter with registered full flag.
// Revision : 1.0 - initial release
// ============================================================================
module occupancy_counter #(
    parameter int CAPACITY = 32
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          inc,
    input  logic                          dec,
    output logic [$clog2(CAPACITY+1)-1:0] count,
    output logic                          full
);
    import gate_pkg::*;

    localparam int                CNT_W = $clog2(CAPACITY+1);
    localparam logic [CNT_W-1:0]  C_CAP = CNT_W'(CAPACITY);

    logic [CNT_W-1:0] w_count_next;

    // Simultaneous inc and dec cancel out
    always_comb begin
        w_count_next = count;
        if (inc && !dec && (count != C_CAP)) begin
            w_count_next = count + CNT_W'(1);
        end else if (dec && !inc && (count != '0)) begin
            w_count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
            full  <= 1'b0;
        end else begin
            count <= w_count_next;
            full  <= (w_count_next == C_CAP);
        end
    end

endmodule
`default_nettype wire

// File: rtl/gate_controller_param.sv
`default_nettype none
// ============================================================================
// Module   : gate_controller_param
// Brief    : Parametrised parking-gate FSM with PIN lockout, auto-close and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module gate_controller_param #(
    parameter int               PIN_W        = 8,
    parameter logic [PIN_W-1:0] PIN_CORRECTO = 8'h10,
    parameter int               MAX_TRIES    = 3,
    parameter int               OPEN_TIMEOUT = 16,
    parameter int               CAPACITY     = 32
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Vehiculo,
    input  logic                          enterPin,
    input  logic [PIN_W-1:0]              Pin,
    input  logic                          Termino,
    input  logic                          Salida,
    output logic                          Cerrado,
    output logic                          Abierto,
    output logic                          Alarma,
    output logic                          Bloqueo,
    output logic                          Lleno,
    output logic                          Rechazo,
    output logic                          Expirado,
    output logic [$clog2(CAPACITY+1)-1:0] Ocupacion
);
    import gate_pkg::*;

    localparam int             AW          = $clog2(MAX_TRIES+1);
    localparam int             TW          = $clog2(OPEN_TIMEOUT+1);
    localparam logic [AW-1:0]  C_MAX_TRIES = AW'(MAX_TRIES);
    localparam logic [TW-1:0]  C_TIMEOUT   = TW'(OPEN_TIMEOUT);

    gate_state_t   r_state, w_state_next;
    logic [AW-1:0] r_attempts, w_attempts_next, w_attempts_inc;
    logic [TW-1:0] r_timer, w_timer_next;
    logic          r_rechazo, w_rechazo_next;
    logic          r_expirado, w_expirado_next;
    logic          w_occ_inc;
    logic          w_pin_ok;

    assign w_pin_ok       = (Pin == PIN_CORRECTO);
    assign w_attempts_inc = r_attempts + AW'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= CERRADA;
            r_attempts <= '0;
            r_timer    <= '0;
            r_rechazo  <= 1'b0;
            r_expirado <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_attempts <= w_attempts_next;
            r_timer    <= w_timer_next;
            r_rechazo  <= w_rechazo_next;
            r_expirado <= w_expirado_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_attempts_next = r_attempts;
        w_timer_next    = '0;
        w_rechazo_next  = 1'b0;
        w_expirado_next = 1'b0;
        w_occ_inc       = 1'b0;
        case (r_state)
            CERRADA: begin
                if (Vehiculo && enterPin) begin
                    if (w_pin_ok) begin
                        w_attempts_next = '0;
                        if (Lleno) begin
                            w_rechazo_next = 1'b1;
                        end else begin
                            w_state_next = ABIERTA;
                            w_timer_next = C_TIMEOUT;
                        end
                    end else begin
                        w_attempts_next = w_attempts_inc;
                        if (w_attempts_inc == C_MAX_TRIES) begin
                            w_state_next = SUSPENDIDA;
                        end
                    end
                end
            end
            SUSPENDIDA: begin
                if (enterPin && w_pin_ok) begin
                    w_attempts_next = '0;
                    if (Lleno) begin
                        w_state_next   = CERRADA;
                        w_rechazo_next = 1'b1;
                    end else begin
                        w_state_next = ABIERTA;
                        w_timer_next = C_TIMEOUT;
                    end
                end
            end
            ABIERTA: begin
                w_timer_next = r_timer - TW'(1);
                // Passage completion wins over a simultaneous timeout
                if (Termino) begin
                    w_occ_inc    = 1'b1;
                    w_timer_next = '0;
                    w_state_next = Vehiculo ? BLOQUEADA : CERRADA;
                end else if (r_timer <= TW'(1)) begin
                    w_timer_next    = '0;
                    w_expirado_next = 1'b1;
                    w_state_next    = CERRADA;
                end
            end
            BLOQUEADA: begin
                if (enterPin && w_pin_ok) begin
                    if (Lleno) begin
                        w_state_next   = CERRADA;
                        w_rechazo_next = 1'b1;
                    end else begin
                        w_state_next = ABIERTA;
                        w_timer_next = C_TIMEOUT;
                    end
                end
            end
            default: begin
                w_state_next = CERRADA;
            end
        endcase
    end

    occupancy_counter #(
        .CAPACITY (CAPACITY)
    ) u_occupancy (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (w_occ_inc),
        .dec   (Salida),
        .count (Ocupacion),
        .full  (Lleno)
    );

    assign {Cerrado, Abierto, Alarma, Bloqueo} = decode_outputs(r_state);
    assign Rechazo  = r_rechazo;
    assign Expirado = r_expirado;

endmodule
`default_nettype wire

// File: tb/tb_gate_controller_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_controller_param
// Brief    : Directed self-checking bench for gate_controller_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_controller_param;

    logic       Clk = 1'b0;
    logic       Reset, Vehiculo, enterPin, Termino, Salida;
    logic [7:0] Pin;
    logic       Cerrado, Abierto, Alarma, Bloqueo, Lleno, Rechazo, Expirado;
    logic [1:0] Ocupacion;

    int errors = 0;
    int checks = 0;

    gate_controller_param #(
        .PIN_W        (8),
        .PIN_CORRECTO (8'h10),
        .MAX_TRIES    (3),
        .OPEN_TIMEOUT (8),
        .CAPACITY     (2)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Vehiculo  (Vehiculo),
        .enterPin  (enterPin),
        .Pin       (Pin),
        .Termino   (Termino),
        .Salida    (Salida),
        .Cerrado   (Cerrado),
        .Abierto   (Abierto),
        .Alarma    (Alarma),
        .Bloqueo   (Bloqueo),
        .Lleno     (Lleno),
        .Rechazo   (Rechazo),
        .Expirado  (Expirado),
        .Ocupacion (Ocupacion)
    );

    always #5 Clk = ~Clk;

    // Packed as {Cerrado, Abierto, Alarma, Bloqueo, Lleno, Rechazo, Expirado}
    function automatic logic [6:0] outs();
        return {Cerrado, Abierto, Alarma, Bloqueo, Lleno, Rechazo, Expirado};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic e, input logic [7:0] p,
                         input logic t, input logic s);
        Vehiculo = v; enterPin = e; Pin = p; Termino = t; Salida = s;
    endtask

    initial begin
        Reset = 1'b1;
        drive(0, 0, 8'h00, 0, 0);
        tick(); tick();
        check("reset_outs", 32'(outs()), 32'b1000000);
        check("reset_occ", 32'(Ocupacion), 0);
        Reset = 1'b0;

        // 1: correct PIN opens, clean pass closes and counts
        drive(1, 1, 8'h10, 0, 0); tick();
        check("s1_open", 32'(outs()), 32'b0100000);
        drive(0, 0, 8'h00, 1, 0); tick();
        check("s1_close", 32'(outs()), 32'b1000000);
        check("s1_occ", 32'(Ocupacion), 1);

        // 2: lockout after three wrong PINs
        drive(1, 1, 8'h11, 0, 0); tick();
        check("s2_try1", 32'(outs()), 32'b1000000);
        tick();
        check("s2_try2", 32'(outs()), 32'b1000000);
        tick();
        check("s2_susp", 32'(outs()), 32'b1010000);
        tick();
        check("s2_susp_wrong", 32'(outs()), 32'b1010000);
        drive(1, 1, 8'h10, 0, 0); tick();
        check("s2_unlock", 32'(outs()), 32'b0100000);

        // 3: gate already open one cycle; seven more, then auto-close
        drive(0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("s3_open_hold", 32'(outs()), 32'b0100000);
        end
        tick();
        check("s3_expire", 32'(outs()), 32'b1000001);
        check("s3_occ", 32'(Ocupacion), 1);
        tick();
        check("s3_exp_pulse", 32'(Expirado), 0);

        drive(0, 0, 8'h00, 0, 1); tick();
        check("salida_to0", 32'(Ocupacion), 0);

        // 4: tailgater blocks, correct PIN reopens with fresh timer
        drive(1, 1, 8'h10, 0, 0); tick();
        check("s4_open", 32'(outs()), 32'b0100000);
        drive(1, 0, 8'h00, 1, 0); tick();
        check("s4_block", 32'(outs()), 32'b0011000);
        check("s4_occ", 32'(Ocupacion), 1);
        drive(0, 1, 8'h11, 0, 0); tick();
        check("s4_block_wrong", 32'(outs()), 32'b0011000);
        drive(0, 1, 8'h10, 0, 0); tick();
        check("s4_reopen", 32'(outs()), 32'b0100000);
        drive(0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 7; i++) tick();
        check("s4_reload_hold", 32'(outs()), 32'b0100000);
        tick();
        check("s4_reload_exp", 32'(outs()), 32'b1000001);

        // 5: fill the lot, refusal, Salida handling
        drive(1, 1, 8'h10, 0, 0); tick();
        drive(0, 0, 8'h00, 1, 0); tick();
        check("s5_full", 32'(outs()), 32'b1000100);
        check("s5_occ2", 32'(Ocupacion), 2);
        drive(1, 1, 8'h10, 0, 0); tick();
        check("s5_rechazo", 32'(outs()), 32'b1000110);
        drive(0, 0, 8'h00, 0, 0); tick();
        check("s5_rech_pulse", 32'(outs()), 32'b1000100);
        drive(0, 0, 8'h00, 0, 1); tick();
        check("s5_salida", 32'(outs()), 32'b1000000);
        check("s5_occ1", 32'(Ocupacion), 1);
        // pass completes in the same cycle as a Salida: net unchanged
        drive(1, 1, 8'h10, 0, 0); tick();
        drive(0, 0, 8'h00, 1, 1); tick();
        check("s5_inc_dec", 32'(Ocupacion), 1);
        drive(0, 0, 8'h00, 0, 1); tick();
        check("s5_occ0", 32'(Ocupacion), 0);
        tick();
        check("s5_sat0", 32'(Ocupacion), 0);

        // 6: reset mid-open clears everything
        drive(1, 1, 8'h10, 0, 0); tick();
        drive(0, 0, 8'h00, 1, 0); tick();
        drive(1, 1, 8'h10, 0, 0); tick();
        check("s6_open", 32'(outs()), 32'b0100000);
        check("s6_occ1", 32'(Ocupacion), 1);
        drive(1, 1, 8'h11, 0, 0); tick();
        tick();
        Reset = 1'b1; drive(0, 0, 8'h00, 0, 0); tick();
        check("s6_reset", 32'(outs()), 32'b1000000);
        check("s6_reset_occ", 32'(Ocupacion), 0);
        Reset = 1'b0;
        drive(1, 1, 8'h11, 0, 0); tick(); tick();
        check("s6_attempts_clr", 32'(outs()), 32'b1000000);
        tick();
        check("s6_relock", 32'(outs()), 32'b1010000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
